// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding,
// and the fixed results for divide-by-zero and signed overflow.
package alu_pkg;

  // Opcode map; 0-8 are the original combinational ALU operations.
  localparam logic [3:0] OP_OR      = 4'd0;
  localparam logic [3:0] OP_AND     = 4'd1;
  localparam logic [3:0] OP_XOR     = 4'd2;
  localparam logic [3:0] OP_ADD     = 4'd3;
  localparam logic [3:0] OP_SUB     = 4'd4;
  localparam logic [3:0] OP_SHL     = 4'd5;
  localparam logic [3:0] OP_SHR     = 4'd6;
  localparam logic [3:0] OP_MULT    = 4'd7;
  localparam logic [3:0] OP_NOTA    = 4'd8;
  localparam logic [3:0] OP_SHIFTRS = 4'd9;
  localparam logic [3:0] OP_DIV     = 4'd10;
  localparam logic [3:0] OP_MOD     = 4'd11;
  localparam logic [3:0] OP_MULTH   = 4'd12;

  // FSM state encoding; DIV and FIX are only reachable with the divider built in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Widest operand the constant helpers below can describe.
  localparam int MAX_W = 128;

  // Quotient returned for a zero divisor: all ones in the low w bits.
  function automatic logic [MAX_W-1:0] div0_quot(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  // Most negative w-bit value; also the quotient for (most negative) / -1.
  function automatic logic [MAX_W-1:0] ovf_quot(input int w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB
// first, WIDTH cycles after i_start. o_done is high during the cycle whose
// closing edge produces the last bit; quotient/remainder are final from the
// following cycle and hold until the next i_start.
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;

  // Partial remainder shifted left with the next dividend bit, then a trial
  // subtract; bit WIDTH of the difference is set when the divisor did not fit.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_trial[WIDTH];

  // Load operands on start, then shift one quotient bit into r_q per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
    end else if (i_start) begin
      r_count <= CNT_W'(WIDTH);
      r_q     <= i_dividend;
      r_rem   <= '0;
      r_dvs   <= i_divisor;
    end else if (r_count != '0) begin
      r_q     <= {r_q[WIDTH-2:0], w_fits};
      r_rem   <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_count <= r_count - 1'b1;
    end
  end

  assign o_quotient  = r_q;
  assign o_remainder = r_rem;
  assign o_done      = (r_count == CNT_W'(1));

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake. Single-cycle operations
// complete one cycle after start; DIV/MOD run on an iterative divider and
// complete WIDTH+2 cycles after start. The divider and its DIV/FIX states
// are only built when ALU_SEQ_DIVIDER_EN is defined; otherwise DIV/MOD are
// single-cycle and return 0, and busy is tied low.
//
// Handshake: start is sampled at a rising edge only while the FSM is IDLE
// (busy=0) and is otherwise dropped; operands need to be valid only in that
// cycle. done is a one-cycle pulse; y/bga/bea change only together with done
// and hold until the next done. A start in the done cycle is accepted.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             sig,
  input  logic             skip,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             bga,
  output logic             bea,
  output state_t           dbg_state
);

  state_t             r_state;
  logic               r_done;
  logic [WIDTH-1:0]   r_y;
  logic               r_bga;
  logic               r_bea;

  logic [SHAMT_W-1:0] w_shamt;
  logic [2*WIDTH-1:0] w_ax;
  logic [2*WIDTH-1:0] w_bx;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_alu;
  logic               w_bga;
  logic               w_bea;

  assign w_shamt = b[SHAMT_W-1:0];

  // Operands extended to 2*WIDTH so one multiplier serves MULT and both
  // MULTH flavours; the low half is the same either way.
  assign w_ax   = sig ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign w_bx   = sig ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign w_prod = w_ax * w_bx;

  assign w_bga = sig ? ($signed(b) > $signed(a)) : (b > a);
  assign w_bea = (b == a);

  // Single-cycle result; shift amounts >= WIDTH fall out of the shift
  // operators as 0 (or sign fill for the arithmetic shift).
  always_comb begin
    w_alu = '0;
    case (opcode)
      OP_OR:      w_alu = a | b;
      OP_AND:     w_alu = a & b;
      OP_XOR:     w_alu = a ^ b;
      OP_ADD:     w_alu = a + b;
      OP_SUB:     w_alu = a - b;
      OP_SHL:     w_alu = a << w_shamt;
      OP_SHR:     w_alu = a >> w_shamt;
      OP_MULT:    w_alu = w_prod[WIDTH-1:0];
      OP_NOTA:    w_alu = ~a;
      OP_SHIFTRS: w_alu = $signed(a) >>> w_shamt;
      OP_MULTH:   w_alu = w_prod[2*WIDTH-1:WIDTH];
      default:    w_alu = '0;
    endcase
  end

`ifdef ALU_SEQ_DIVIDER_EN
  localparam logic [WIDTH-1:0] C_DIV0_Q = WIDTH'(div0_quot(WIDTH));
  localparam logic [WIDTH-1:0] C_MIN    = WIDTH'(ovf_quot(WIDTH));

  logic               r_busy;
  logic               r_is_mod;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_a_lat;
  logic               r_bga_p;
  logic               r_bea_p;

  logic               w_div_req;
  logic               w_div_start;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_fix_q;
  logic [WIDTH-1:0]   w_fix_r;

  assign w_div_req   = ~skip & ((opcode == OP_DIV) | (opcode == OP_MOD));
  assign w_div_start = start & (r_state == ST_IDLE) & w_div_req;
  assign w_abs_a     = (sig & a[WIDTH-1]) ? -a : a;
  assign w_abs_b     = (sig & b[WIDTH-1]) ? -b : b;

  alu_seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_quotient  (w_uq),
    .o_remainder (w_ur),
    .o_done      (w_div_done)
  );

  // Sign fix-up of the unsigned core result; zero divisor and the single
  // overflowing signed case return fixed values instead.
  assign w_fix_q = r_div0 ? C_DIV0_Q :
                   r_ovf  ? C_MIN    :
                   (r_neg_q ? -w_uq : w_uq);
  assign w_fix_r = r_div0 ? r_a_lat  :
                   r_ovf  ? '0       :
                   (r_neg_r ? -w_ur : w_ur);

  assign busy = r_busy;
`else
  assign busy = 1'b0;
`endif

  // Operation FSM: IDLE accepts work, DIV waits on the core, FIX writes back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_bga   <= 1'b0;
      r_bea   <= 1'b0;
`ifdef ALU_SEQ_DIVIDER_EN
      r_busy   <= 1'b0;
      r_is_mod <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_a_lat  <= '0;
      r_bga_p  <= 1'b0;
      r_bea_p  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
`ifdef ALU_SEQ_DIVIDER_EN
            if (w_div_req) begin
              r_is_mod <= (opcode == OP_MOD);
              r_neg_q  <= sig & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r  <= sig & a[WIDTH-1];
              r_div0   <= (b == '0);
              r_ovf    <= sig & (a == C_MIN) & (b == '1);
              r_a_lat  <= a;
              r_bga_p  <= w_bga;
              r_bea_p  <= w_bea;
              r_busy   <= 1'b1;
              r_state  <= ST_DIV;
            end else
`endif
            begin
              r_y    <= skip ? b : w_alu;
              r_bga  <= w_bga;
              r_bea  <= w_bea;
              r_done <= 1'b1;
            end
          end
        end
`ifdef ALU_SEQ_DIVIDER_EN
        ST_DIV: begin
          if (w_div_done) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_y     <= r_is_mod ? w_fix_r : w_fix_q;
          r_bga   <= r_bga_p;
          r_bea   <= r_bea_p;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign y         = r_y;
  assign bga       = r_bga;
  assign bea       = r_bea;
  assign dbg_state = r_state;

endmodule
